// File: rtl/logic_prim_pkg.sv
// Shared constants and helpers for the logic primitive unit.
package logic_prim_pkg;

   localparam int DEC_SEL_W = 3;
   localparam int DEC_OUT_W = 8;

   localparam logic [DEC_OUT_W-1:0] DEC_DISABLED = 8'h00;

   // One-hot decode of a select value, forced to all zeros when disabled.
   function automatic logic [DEC_OUT_W-1:0] dec_onehot(
      input logic [DEC_SEL_W-1:0] sel,
      input logic                 en
   );
      logic [DEC_OUT_W-1:0] r;
      r = DEC_DISABLED;
      if (en) begin
         r = DEC_OUT_W'(1) << sel;
      end
      return r;
   endfunction

endpackage

// File: rtl/prim_fa_bit.sv
// Single-bit full adder cell; chained by the top to form a ripple-carry adder.
module prim_fa_bit (
   input  logic x,
   input  logic y,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = x ^ y ^ cin;
   assign cout = (x & y) | (x & cin) | (y & cin);

endmodule

// File: rtl/logic_prim_unit.sv
// Registered primitive unit: bitwise AND, ripple-carry add with carry-in,
// and 3-to-8 one-hot decode, all behind a single valid qualifier.
module logic_prim_unit
   import logic_prim_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_valid,
   input  logic [WIDTH-1:0]     i_a,
   input  logic [WIDTH-1:0]     i_b,
   input  logic                 i_c,
   input  logic [DEC_SEL_W-1:0] i_dec_in,
   input  logic                 i_dec_en,
   output logic                 o_valid,
   output logic [WIDTH-1:0]     o_and,
   output logic [WIDTH-1:0]     o_sum,
   output logic                 o_carry,
   output logic [DEC_OUT_W-1:0] o_dec
);

   // Ripple chain: carry_w[0] is the external carry-in, carry_w[WIDTH] the carry-out.
   logic [WIDTH:0]   carry_w;
   logic [WIDTH-1:0] sum_w;

   assign carry_w[0] = i_c;

   for (genvar g = 0; g < WIDTH; g++) begin : g_fa
      prim_fa_bit u_fa (
         .x    (i_a[g]),
         .y    (i_b[g]),
         .cin  (carry_w[g]),
         .sum  (sum_w[g]),
         .cout (carry_w[g+1])
      );
   end

   logic                 valid_q;
   logic [WIDTH-1:0]     and_q,   and_d;
   logic [WIDTH-1:0]     sum_q,   sum_d;
   logic                 carry_q, carry_d;
   logic [DEC_OUT_W-1:0] dec_q,   dec_d;

   // Next-state: load fresh results on a valid sample, otherwise hold.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no latch is inferred.
      and_d   = and_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      dec_d   = dec_q;
      if (i_valid) begin
         and_d   = i_a & i_b;
         sum_d   = sum_w;
         carry_d = carry_w[WIDTH];
         dec_d   = dec_onehot(i_dec_in, i_dec_en);
      end
   end

   // Output registers with asynchronous clear; valid tracks i_valid every cycle.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (!i_rst_n) begin
         valid_q <= 1'b0;
         and_q   <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         dec_q   <= DEC_DISABLED;
      end else begin
         valid_q <= i_valid;
         and_q   <= and_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         dec_q   <= dec_d;
      end
   end

   assign o_valid = valid_q;
   assign o_and   = and_q;
   assign o_sum   = sum_q;
   assign o_carry = carry_q;
   assign o_dec   = dec_q;

endmodule

// File: tb/tb_logic_prim_unit.sv
// Directed self-checking bench for logic_prim_unit (WIDTH = 4).
module tb_logic_prim_unit;

   localparam int WIDTH = 4;

   logic             i_clk;
   logic             i_rst_n;
   logic             i_valid;
   logic [WIDTH-1:0] i_a;
   logic [WIDTH-1:0] i_b;
   logic             i_c;
   logic [2:0]       i_dec_in;
   logic             i_dec_en;
   logic             o_valid;
   logic [WIDTH-1:0] o_and;
   logic [WIDTH-1:0] o_sum;
   logic             o_carry;
   logic [7:0]       o_dec;

   int n_checks = 0;
   int n_fail   = 0;

   logic_prim_unit #(.WIDTH(WIDTH)) dut (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_valid  (i_valid),
      .i_a      (i_a),
      .i_b      (i_b),
      .i_c      (i_c),
      .i_dec_in (i_dec_in),
      .i_dec_en (i_dec_en),
      .o_valid  (o_valid),
      .o_and    (o_and),
      .o_sum    (o_sum),
      .o_carry  (o_carry),
      .o_dec    (o_dec)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_checks++;
      if (observed !== expected) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic drive(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic c, input logic [2:0] sel, input logic en);
      i_valid  = v;
      i_a      = a;
      i_b      = b;
      i_c      = c;
      i_dec_in = sel;
      i_dec_en = en;
   endtask

   // Advance past the next rising edge and settle before sampling.
   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   initial begin
      logic [4:0] full;
      logic [7:0] exp_dec;

      i_rst_n = 1'b1;
      drive(1'b0, '0, '0, 1'b0, 3'd0, 1'b0);
      #1;

      // Reset with random inputs applied.
      i_rst_n = 1'b0;
      drive(1'b1, 4'($urandom), 4'($urandom), 1'($urandom), 3'($urandom), 1'b1);
      step();
      step();
      check("rst_valid", 32'(o_valid), 32'd0);
      check("rst_and",   32'(o_and),   32'd0);
      check("rst_sum",   32'(o_sum),   32'd0);
      check("rst_carry", 32'(o_carry), 32'd0);
      check("rst_dec",   32'(o_dec),   32'h00);

      // Release and perform the wrap-around add.
      @(negedge i_clk);
      i_rst_n = 1'b1;
      drive(1'b1, 4'hF, 4'hF, 1'b1, 3'd0, 1'b0);
      step();
      check("wrap_valid", 32'(o_valid), 32'd1);
      check("wrap_and",   32'(o_and),   32'hF);
      check("wrap_sum",   32'(o_sum),   32'hF);
      check("wrap_carry", 32'(o_carry), 32'd1);

      // AND truth table on bit 0: 00, 01, 10, 11 -> 0, 0, 0, 1.
      for (int i = 0; i < 4; i++) begin
         logic [1:0] ab;
         ab = 2'(i);
         drive(1'b1, {3'b0, ab[1]}, {3'b0, ab[0]}, 1'b0, 3'd0, 1'b0);
         step();
         check($sformatf("and_bit0_%0d", i), 32'(o_and[0]), (i == 3) ? 32'd1 : 32'd0);
         check($sformatf("and_word_%0d", i), 32'(o_and), (i == 3) ? 32'd1 : 32'd0);
      end

      // Full-adder truth table on bit 0: sum bits {o_sum[1], o_sum[0]}.
      for (int i = 0; i < 8; i++) begin
         logic [2:0] abc;
         abc = 3'(i);
         drive(1'b1, {3'b0, abc[2]}, {3'b0, abc[1]}, abc[0], 3'd0, 1'b0);
         step();
         full = 5'(abc[2]) + 5'(abc[1]) + 5'(abc[0]);
         check($sformatf("fa_sum_%0d", i),   32'(o_sum),   32'(full[3:0]));
         check($sformatf("fa_carry_%0d", i), 32'(o_carry), 32'd0);
      end

      // 9 + 8 + 0 = 17 -> sum 1, carry 1.
      drive(1'b1, 4'h9, 4'h8, 1'b0, 3'd0, 1'b0);
      step();
      check("add98_sum",   32'(o_sum),   32'h1);
      check("add98_carry", 32'(o_carry), 32'd1);

      // Decoder sweep with enable.
      exp_dec = 8'h01;
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 4'h0, 4'h0, 1'b0, 3'(i), 1'b1);
         step();
         check($sformatf("dec_sel_%0d", i), 32'(o_dec), 32'(exp_dec));
         exp_dec = {exp_dec[6:0], 1'b0};
      end
      drive(1'b1, 4'h0, 4'h0, 1'b0, 3'b101, 1'b0);
      step();
      check("dec_disabled", 32'(o_dec), 32'h00);

      // Hold: load a sample then drop valid with all inputs changed.
      drive(1'b1, 4'h5, 4'h3, 1'b0, 3'd2, 1'b1);
      step();
      check("load_and", 32'(o_and), 32'h1);
      check("load_sum", 32'(o_sum), 32'h8);
      check("load_dec", 32'(o_dec), 32'h04);
      drive(1'b0, 4'hA, 4'hF, 1'b1, 3'd7, 1'b1);
      step();
      check("hold_valid", 32'(o_valid), 32'd0);
      check("hold_and",   32'(o_and),   32'h1);
      check("hold_sum",   32'(o_sum),   32'h8);
      check("hold_carry", 32'(o_carry), 32'd0);
      check("hold_dec",   32'(o_dec),   32'h04);

      // Async reset between edges: load nonzero state, then pulse reset mid-cycle.
      drive(1'b1, 4'hF, 4'hF, 1'b1, 3'd7, 1'b1);
      step();
      check("pre_areset_dec", 32'(o_dec), 32'h80);
      #2;
      i_rst_n = 1'b0;
      #1;
      check("areset_valid", 32'(o_valid), 32'd0);
      check("areset_and",   32'(o_and),   32'd0);
      check("areset_sum",   32'(o_sum),   32'd0);
      check("areset_carry", 32'(o_carry), 32'd0);
      check("areset_dec",   32'(o_dec),   32'h00);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      drive(1'b1, 4'h6, 4'h3, 1'b1, 3'd1, 1'b1);
      step();
      check("post_and",   32'(o_and),   32'h2);
      check("post_sum",   32'(o_sum),   32'hA);
      check("post_carry", 32'(o_carry), 32'd0);
      check("post_dec",   32'(o_dec),   32'h02);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
